// File: rtl/data_memory_responder_pkg.sv
// Shared types and defaults for the data memory responder.
package data_memory_responder_pkg;

  localparam int unsigned DEFAULT_AWIDTH       = 15;
  localparam int unsigned DEFAULT_DWIDTH       = 32;
  localparam int unsigned DEFAULT_DEPTH        = 1024;
  localparam int unsigned DEFAULT_READ_LATENCY = 2;

  // Latency counter width; covers READ_LATENCY up to 7.
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_WAIT = 2'd1,
    ST_RESPOND   = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_responder_array.sv
// Single-port synchronous RAM with write enable and registered read port.
module data_memory_responder_array #(
  parameter int unsigned AWIDTH_INT = 10,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [AWIDTH_INT-1:0] addr,
  input  logic [DWIDTH-1:0]     wdata,
  output logic [DWIDTH-1:0]     rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Write port plus read snapshot; rdata holds until the next accepted read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the load/store port: one-cycle writes,
// fixed-latency reads with busy back-pressure and error pulses.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned AWIDTH       = DEFAULT_AWIDTH,
  parameter int unsigned DWIDTH       = DEFAULT_DWIDTH,
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              read_enable,
  input  logic              write_enable,
  output logic [DWIDTH-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              error
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [DWIDTH-1:0] snap_q;
  logic              in_range;
  logic              can_accept;
  logic              req_bad;
  logic              mem_we;
  logic              mem_re;

  // Request qualification: only an idle, non-busy responder looks at requests.
  assign in_range   = 32'(addr) < 32'(DEPTH);
  assign can_accept = (state == ST_IDLE) && !busy && !reset;
  assign req_bad    = (read_enable && write_enable) ||
                      ((read_enable || write_enable) && !in_range);
  assign mem_we     = can_accept && write_enable && !read_enable && in_range;
  assign mem_re     = can_accept && read_enable && !write_enable && in_range;

  data_memory_responder_array #(
    .AWIDTH_INT (IW),
    .DWIDTH     (DWIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr[IW-1:0]),
    .wdata (wdata),
    .rdata (snap_q)
  );

  // Read sequencing FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      counter     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      error       <= 1'b0;
      case (state)
        ST_IDLE: begin
          // busy stays up for the cycle after the response, then drops here.
          busy <= 1'b0;
          if (!busy) begin
            if (req_bad) begin
              error <= 1'b1;
            end else if (read_enable) begin
              busy    <= 1'b1;
              counter <= CNT_W'(READ_LATENCY - 1);
              state   <= (READ_LATENCY == 1) ? ST_RESPOND : ST_READ_WAIT;
            end
          end
        end
        ST_READ_WAIT: begin
          busy    <= 1'b1;
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            state <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          busy        <= 1'b1;
          rdata       <= snap_q;
          rdata_valid <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed scenarios plus
// randomized traffic compared against a transaction-level reference model.
module tb_data_memory_responder;

  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned RL    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          read_enable;
  logic          write_enable;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          busy;
  logic          error;

  always #5 clk = ~clk;

  data_memory_responder #(
    .AWIDTH       (AW),
    .DWIDTH       (DW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (RL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .wdata        (wdata),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .busy         (busy),
    .error        (error)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: memory image plus the schedule of the one read in flight.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            known   [DEPTH];
  longint        edge_n    = 0;
  longint        busy_last = -1;
  longint        resp_edge = 0;
  bit            pending   = 1'b0;
  logic [DW-1:0] resp_data = '0;
  bit            resp_known = 1'b0;
  logic [DW-1:0] exp_rdata = '0;
  bit            rdata_known = 1'b0;
  bit            exp_valid = 1'b0;
  bit            exp_busy  = 1'b0;
  bit            exp_error = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge with the inputs sampled at that edge.
  task automatic model_edge(input bit rst, input bit re, input bit we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit busy_in;
    int idx;
    edge_n++;
    exp_valid = 1'b0;
    exp_error = 1'b0;
    if (rst) begin
      pending     = 1'b0;
      busy_last   = -1;
      exp_rdata   = '0;
      rdata_known = 1'b1;
    end else begin
      if (pending && resp_edge == edge_n) begin
        exp_valid   = 1'b1;
        exp_rdata   = resp_data;
        rdata_known = resp_known;
        pending     = 1'b0;
      end
      busy_in = (edge_n - 1) <= busy_last;
      if (!busy_in && (re || we)) begin
        if ((re && we) || (32'(a) >= DEPTH)) begin
          exp_error = 1'b1;
        end else begin
          idx = int'(a);
          if (we) begin
            ref_mem[idx] = d;
            known[idx]   = 1'b1;
          end else begin
            pending    = 1'b1;
            resp_edge  = edge_n + longint'(RL);
            resp_data  = ref_mem[idx];
            resp_known = known[idx];
            busy_last  = edge_n + longint'(RL);
          end
        end
      end
    end
    exp_busy = edge_n <= busy_last;
  endtask

  // Drive one cycle of inputs, update the model at the edge, compare at the falling edge.
  task automatic step(input bit rst, input bit re, input bit we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    reset        = rst;
    read_enable  = re;
    write_enable = we;
    addr         = a;
    wdata        = d;
    @(posedge clk);
    model_edge(rst, re, we, a, d);
    @(negedge clk);
    check_eq("rdata_valid", 32'(rdata_valid), 32'(exp_valid));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("error", 32'(error), 32'(exp_error));
    if (rdata_known) begin
      check_eq("rdata", rdata, exp_rdata);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int busy_cnt;
    int seen_at;
    logic [AW-1:0] ra;
    int r;
    bit rre, rwe, rrst;

    for (int i = 0; i < int'(DEPTH); i++) known[i] = 1'b0;
    reset = 1'b1; read_enable = 1'b0; write_enable = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);

    // Reset held two cycles.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);

    // Write then read addr 5: latency and busy length.
    step(1'b0, 1'b0, 1'b1, AW'(5), 32'hDEADBEEF);
    step(1'b0, 1'b1, 1'b0, AW'(5), '0);
    busy_cnt = busy ? 1 : 0;
    seen_at  = -1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0);
      if (busy) busy_cnt++;
      if (rdata_valid) begin
        seen_at = i;
        check_eq("t2_data", rdata, 32'hDEADBEEF);
      end
    end
    check_eq("t2_latency", 32'(seen_at), 32'(RL - 1));
    check_eq("t2_busy_cycles", 32'(busy_cnt), 32'(RL + 1));

    // Both enables on addr 3: error, memory untouched.
    step(1'b0, 1'b0, 1'b1, AW'(3), 32'h0000_3333);
    step(1'b0, 1'b1, 1'b1, AW'(3), 32'h1234_5678);
    step(1'b0, 1'b1, 1'b0, AW'(3), '0);
    idle(4);

    // Out-of-range read at the top of the address space.
    step(1'b0, 1'b1, 1'b0, AW'(15'h7FFF), '0);
    idle(2);
    // First out-of-range word and a wrapped alias of a valid index.
    step(1'b0, 1'b0, 1'b1, AW'(DEPTH), 32'hBAD0_0001);
    step(1'b0, 1'b1, 1'b0, AW'(DEPTH + 5), '0);
    step(1'b0, 1'b0, 1'b1, AW'(DEPTH - 1), 32'hCAFE_F00D);
    step(1'b0, 1'b1, 1'b0, AW'(DEPTH - 1), '0);
    idle(4);

    // Write while busy is dropped.
    step(1'b0, 1'b1, 1'b0, AW'(5), '0);
    step(1'b0, 1'b0, 1'b1, AW'(5), 32'h0000_0001);
    idle(4);
    step(1'b0, 1'b1, 1'b0, AW'(5), '0);
    idle(4);

    // Reset during READ_WAIT aborts the read.
    step(1'b0, 1'b1, 1'b0, AW'(5), '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(4);
    step(1'b0, 1'b1, 1'b0, AW'(5), '0);
    idle(4);

    // Randomized traffic over a small address window plus out-of-range addresses.
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 16)       ra = AW'(r);
      else if (r == 16) ra = AW'(DEPTH - 1);
      else if (r == 17) ra = AW'(DEPTH);
      else if (r == 18) ra = AW'(15'h7FFF);
      else              ra = AW'(DEPTH + $urandom_range(0, DEPTH - 1));
      rre  = ($urandom_range(0, 2) == 0);
      rwe  = ($urandom_range(0, 2) == 0);
      rrst = ($urandom_range(0, 59) == 0);
      step(rrst, rre, rwe, ra, DW'($urandom));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
